vend_txn_ctrl: RTL

Parametrised transaction controller for the micro-vending machine. It replaces the fixed two-item controller with a cart of up to MAX_ITEMS line items, overflow-checked money arithmetic, a payment inactivity timeout, and automatic greedy change/refund output one coin per cycle. It sits between the debounced button/coin front-end and the 7-segment display driver, which reads its totals.

---
 rtl/vend_pkg.sv | 67 ++++++
 rtl/vend_txn_ctrl_if.sv | 35 +++
 rtl/vend_price_lut.sv | 14 +
 rtl/vend_txn_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller: state codes,
// coin denominations, the goods price table and the greedy change picker.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_PAY      = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4,
        ST_REFUND   = 3'd5
    } state_t;

    localparam int PRICE_W = 4;
    localparam int COIN_W  = 5;

    localparam int COIN_B1  = 0;
    localparam int COIN_B5  = 1;
    localparam int COIN_B10 = 2;
    localparam int COIN_B20 = 3;
    localparam int COIN_B50 = 4;

    localparam logic [5:0] COIN_V1  = 6'd1;
    localparam logic [5:0] COIN_V5  = 6'd5;
    localparam logic [5:0] COIN_V10 = 6'd10;
    localparam logic [5:0] COIN_V20 = 6'd20;
    localparam logic [5:0] COIN_V50 = 6'd50;

    // Code is {type_high, type_low}; a price of 0 marks an unknown code.
    function automatic logic [PRICE_W-1:0] price_of(input logic [5:0] code);
        case (code)
            6'o11: price_of = 4'd3;   6'o12: price_of = 4'd4;
            6'o13: price_of = 4'd6;   6'o14: price_of = 4'd3;
            6'o21: price_of = 4'd10;  6'o22: price_of = 4'd8;
            6'o23: price_of = 4'd9;   6'o24: price_of = 4'd7;
            6'o31: price_of = 4'd4;   6'o32: price_of = 4'd6;
            6'o33: price_of = 4'd15;  6'o34: price_of = 4'd8;
            6'o41: price_of = 4'd9;   6'o42: price_of = 4'd4;
            6'o43: price_of = 4'd5;   6'o44: price_of = 4'd5;
            default: price_of = 4'd0;
        endcase
    endfunction

    // Value of a one-hot coin vector.
    function automatic logic [5:0] coin_value(input logic [COIN_W-1:0] coin);
        logic [5:0] v;
        v = '0;
        if (coin[COIN_B1])  v = v | COIN_V1;
        if (coin[COIN_B5])  v = v | COIN_V5;
        if (coin[COIN_B10]) v = v | COIN_V10;
        if (coin[COIN_B20]) v = v | COIN_V20;
        if (coin[COIN_B50]) v = v | COIN_V50;
        return v;
    endfunction

    function automatic logic [COIN_W-1:0] greedy_coin(input logic [31:0] amt);
        logic [COIN_W-1:0] c;
        c = '0;
        if (amt >= 32'(COIN_V50))      c[COIN_B50] = 1'b1;
        else if (amt >= 32'(COIN_V20)) c[COIN_B20] = 1'b1;
        else if (amt >= 32'(COIN_V10)) c[COIN_B10] = 1'b1;
        else if (amt >= 32'(COIN_V5))  c[COIN_B5]  = 1'b1;
        else if (amt != 32'd0)         c[COIN_B1]  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Front-end / display bundle of the vending transaction controller.
interface vend_txn_ctrl_if #(
    parameter int MONEY_W = 10,
    parameter int QTY_W   = 2
);
    logic               btn_add;
    logic               btn_confirm;
    logic               btn_cancel;
    logic [5:0]         goods_code;
    logic [QTY_W-1:0]   qty;
    logic [4:0]         coin_in;
    logic [2:0]         state_o;
    logic [MONEY_W-1:0] price_total;
    logic [MONEY_W-1:0] paid_total;
    logic [MONEY_W-1:0] change_remain;
    logic [3:0]         cart_count;
    logic               dispense_pulse;
    logic [4:0]         change_coin;
    logic               done;
    logic               err_invalid;
    logic               err_full;
    logic               err_overflow;

    modport master (
        output btn_add, btn_confirm, btn_cancel, goods_code, qty, coin_in,
        input  state_o, price_total, paid_total, change_remain, cart_count,
               dispense_pulse, change_coin, done, err_invalid, err_full, err_overflow
    );

    modport slave (
        input  btn_add, btn_confirm, btn_cancel, goods_code, qty, coin_in,
        output state_o, price_total, paid_total, change_remain, cart_count,
               dispense_pulse, change_coin, done, err_invalid, err_full, err_overflow
    );
endinterface

// File: rtl/vend_price_lut.sv
// Combinational goods-code to price lookup.
module vend_price_lut
    import vend_pkg::*;
(
    input  logic [5:0]         i_code,
    output logic               o_valid,
    output logic [PRICE_W-1:0] o_price
);
    logic [PRICE_W-1:0] w_price;

    assign w_price = price_of(i_code);
    assign o_price = w_price;
    assign o_valid = (w_price != '0);
endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: cart build-up, payment with timeout,
// dispensing and greedy one-coin-per-cycle change/refund.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int MAX_ITEMS   = 4,
    parameter int MONEY_W     = 10,
    parameter int QTY_W       = 2,
    parameter int TIMEOUT_CYC = 100000000
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    vend_txn_ctrl_if.slave bus
);
    // Sums are formed wide enough never to wrap, then range-checked.
    localparam int EXT_W = MONEY_W + PRICE_W + QTY_W + 1;
    localparam logic [EXT_W-1:0] MAX_MONEY = {{(EXT_W-MONEY_W){1'b0}}, {MONEY_W{1'b1}}};
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [3:0] CART_MAX = 4'(MAX_ITEMS);

    state_t              r_state;
    logic [MONEY_W-1:0]  r_price, r_paid, r_change;
    logic [3:0]          r_cart, r_disp_cnt;
    logic [TMR_W-1:0]    r_timer;
    logic                r_dispense, r_done, r_err_inv, r_err_full, r_err_ovf;
    logic [COIN_W-1:0]   r_coin_out;

    logic                w_price_vld;
    logic [PRICE_W-1:0]  w_price;
    logic [EXT_W-1:0]    w_item_sum, w_coin_sum;
    logic [5:0]          w_gval;
    logic [COIN_W-1:0]   w_gcoin;
    logic                w_coin_any, w_coin_1hot, w_activity, w_cancel;

    vend_price_lut u_lut (
        .i_code  (bus.goods_code),
        .o_valid (w_price_vld),
        .o_price (w_price)
    );

    assign w_item_sum  = EXT_W'(r_price) + EXT_W'(w_price) * EXT_W'(bus.qty);
    assign w_coin_sum  = EXT_W'(r_paid) + EXT_W'(coin_value(bus.coin_in));
    assign w_coin_any  = (bus.coin_in != '0);
    assign w_coin_1hot = w_coin_any && ((bus.coin_in & (bus.coin_in - 5'd1)) == '0);
    assign w_activity  = bus.btn_add | bus.btn_confirm | bus.btn_cancel | w_coin_any;
    // An expired idle timer is treated exactly like a cancel press.
    assign w_cancel    = bus.btn_cancel ||
                         ((TIMEOUT_CYC != 0) && !w_activity && (r_timer == TMR_LAST));
    assign w_gcoin     = greedy_coin(32'(r_change));
    assign w_gval      = coin_value(w_gcoin);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_price    <= '0;
            r_paid     <= '0;
            r_change   <= '0;
            r_cart     <= '0;
            r_disp_cnt <= '0;
            r_timer    <= '0;
            r_dispense <= 1'b0;
            r_done     <= 1'b0;
            r_err_inv  <= 1'b0;
            r_err_full <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_coin_out <= '0;
        end else begin
            r_dispense <= 1'b0;
            r_done     <= 1'b0;
            r_err_inv  <= 1'b0;
            r_err_full <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_coin_out <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!bus.btn_cancel && bus.btn_confirm) begin
                        r_state  <= ST_SELECT;
                        r_price  <= '0;
                        r_paid   <= '0;
                        r_change <= '0;
                        r_cart   <= '0;
                    end
                end
                ST_SELECT: begin
                    if (bus.btn_cancel) begin
                        r_state <= ST_IDLE;
                        r_price <= '0;
                        r_paid  <= '0;
                        r_cart  <= '0;
                    end else if (bus.btn_confirm) begin
                        if (r_cart != '0) begin
                            r_state <= ST_PAY;
                            r_timer <= '0;
                        end else begin
                            r_err_inv <= 1'b1;
                        end
                    end else if (bus.btn_add) begin
                        if (!w_price_vld || bus.qty == '0) r_err_inv <= 1'b1;
                        else if (r_cart == CART_MAX)       r_err_full <= 1'b1;
                        else if (w_item_sum > MAX_MONEY)   r_err_ovf <= 1'b1;
                        else begin
                            r_price <= w_item_sum[MONEY_W-1:0];
                            r_cart  <= r_cart + 4'd1;
                        end
                    end
                end
                ST_PAY: begin
                    r_timer <= w_activity ? '0 : r_timer + 1'b1;
                    if (w_cancel) begin
                        if (r_paid == '0) r_state <= ST_IDLE;
                        else begin
                            r_state  <= ST_REFUND;
                            r_change <= r_paid;
                        end
                    end else if (w_coin_any) begin
                        // A coin always wins over a simultaneous confirm.
                        if (!w_coin_1hot)                r_err_inv <= 1'b1;
                        else if (w_coin_sum > MAX_MONEY) r_err_ovf <= 1'b1;
                        else                             r_paid <= w_coin_sum[MONEY_W-1:0];
                    end else if (bus.btn_confirm && r_paid >= r_price) begin
                        r_state    <= ST_DISPENSE;
                        r_change   <= r_paid - r_price;
                        r_disp_cnt <= r_cart;
                    end
                end
                ST_DISPENSE: begin
                    r_dispense <= 1'b1;
                    r_disp_cnt <= r_disp_cnt - 4'd1;
                    if (r_disp_cnt == 4'd1) r_state <= ST_CHANGE;
                end
                ST_CHANGE, ST_REFUND: begin
                    if (r_change != '0) begin
                        r_coin_out <= w_gcoin;
                        r_change   <= r_change - MONEY_W'(w_gval);
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.state_o        = r_state;
    assign bus.price_total    = r_price;
    assign bus.paid_total     = r_paid;
    assign bus.change_remain  = r_change;
    assign bus.cart_count     = r_cart;
    assign bus.dispense_pulse = r_dispense;
    assign bus.change_coin    = r_coin_out;
    assign bus.done           = r_done;
    assign bus.err_invalid    = r_err_inv;
    assign bus.err_full       = r_err_full;
    assign bus.err_overflow   = r_err_ovf;
endmodule
